// File: rtl/rcv_bit_ctrl_if.sv
// UART receive bit-timing bus: raw line in, synchronised line and
// shift/load/status strobes out toward the shift register and RX buffer.
interface rcv_bit_ctrl_if;
   logic serial_in;
   logic serial_sync;
   logic shift_enable;
   logic load_buffer;
   logic framing_error;
   logic busy;

   modport master (
      output serial_in,
      input  serial_sync,
      input  shift_enable,
      input  load_buffer,
      input  framing_error,
      input  busy
   );

   modport slave (
      input  serial_in,
      output serial_sync,
      output shift_enable,
      output load_buffer,
      output framing_error,
      output busy
   );
endinterface

// File: rtl/rcv_bit_ctrl.sv
// UART receive bit-timing controller: start detect, mid-bit shift
// strobes, stop-bit check with load pulse or framing error.
module rcv_bit_ctrl #(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8
) (
   input logic          clk,
   input logic          rst,
   rcv_bit_ctrl_if.slave rx
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BCNT_END = BW'(DATA_BITS);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      LOAD
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          prev_q, prev_d;
   logic          shift_q, shift_d;
   logic          load_q, load_d;
   logic          fe_q, fe_d;
   logic          busy_q, busy_d;

   // Synchroniser and edge history run in every state.
   always_comb begin
      sync1_d = rx.serial_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   // Next-state and registered-output logic; counters restart on
   // each state entry so every sample point is a fixed cnt value.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bcnt_d  = bcnt_q;
      shift_d = 1'b0;
      load_d  = 1'b0;
      fe_d    = fe_q;
      busy_d  = 1'b1;
      unique case (state_q)
         IDLE: begin
            cnt_d  = '0;
            busy_d = 1'b0;
            if (!sync2_q && prev_q) begin
               state_d = START;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (sync2_q) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = DATA;
                  bcnt_d  = '0;
                  fe_d    = 1'b0;
               end
            end
         end
         DATA: begin
            if (cnt_q == CNT_PRE) begin
               shift_d = 1'b1;
               bcnt_d  = bcnt_q + 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (bcnt_q == BCNT_END) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (sync2_q) begin
                  state_d = LOAD;
                  load_d  = 1'b1;
               end else begin
                  state_d = IDLE;
                  fe_d    = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
         LOAD: begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, counter and output registers; sync flops idle high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bcnt_q  <= '0;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         shift_q <= 1'b0;
         load_q  <= 1'b0;
         fe_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         shift_q <= shift_d;
         load_q  <= load_d;
         fe_q    <= fe_d;
         busy_q  <= busy_d;
      end
   end

   assign rx.serial_sync   = sync2_q;
   assign rx.shift_enable  = shift_q;
   assign rx.load_buffer   = load_q;
   assign rx.framing_error = fe_q;
   assign rx.busy          = busy_q;

endmodule

// File: tb/tb_rcv_bit_ctrl.sv
// Directed bench for rcv_bit_ctrl: frames, bad stop, false start,
// back-to-back, stuck-low line and mid-frame reset.
module tb_rcv_bit_ctrl;

   localparam int CPB = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   rcv_bit_ctrl_if bus ();

   rcv_bit_ctrl #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         sh_cyc[$];
   int         ld_cyc[$];
   logic [7:0] ld_dat[$];
   logic [7:0] sr = '0;
   logic       busy_p = 1'b0;
   logic       fe_p = 1'b0;
   int         busy_rise = -1;
   int         busy_fall = -1;
   int         n_rise = 0;
   int         fe_rise = -1;
   int         fe_fall = -1;
   int         both_hi = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Monitor: sample outputs mid-cycle, model the shift register.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.shift_enable && bus.load_buffer) both_hi++;
         if (bus.shift_enable) begin
            sh_cyc.push_back(cyc);
            sr = {bus.serial_sync, sr[7:1]};
         end
         if (bus.load_buffer) begin
            ld_cyc.push_back(cyc);
            ld_dat.push_back(sr);
         end
         if (bus.busy && !busy_p) begin
            busy_rise = cyc;
            n_rise++;
         end
         if (!bus.busy && busy_p) busy_fall = cyc;
         if (bus.framing_error && !fe_p) fe_rise = cyc;
         if (!bus.framing_error && fe_p) fe_fall = cyc;
         busy_p = bus.busy;
         fe_p   = bus.framing_error;
      end
   end

   task automatic clear_log();
      sh_cyc.delete();
      ld_cyc.delete();
      ld_dat.delete();
      n_rise = 0;
   endtask

   task automatic drive_bit(input logic b);
      bus.serial_in = b;
      repeat (CPB) @(negedge clk);
   endtask

   // t0 is the first cycle serial_sync shows the start bit.
   task automatic send_frame(input logic [7:0] d, input logic stop,
                             output int t0);
      t0 = cyc + 2;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop);
   endtask

   task automatic check_shifts(input string tag, input int t0);
      chk({tag, " n_shift"}, sh_cyc.size(), 8);
      for (int k = 0; k < 8; k++) begin
         if (k < sh_cyc.size())
            chk({tag, " shift_cyc"}, sh_cyc[k] - t0, 15 + CPB * k);
      end
   endtask

   int t0, t1;

   initial begin
      bus.serial_in = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst serial_sync", int'(bus.serial_sync), 1);
      chk("rst shift_en", int'(bus.shift_enable), 0);
      chk("rst load", int'(bus.load_buffer), 0);
      chk("rst fe", int'(bus.framing_error), 0);
      chk("rst busy", int'(bus.busy), 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      clear_log();
      send_frame(8'hA5, 1'b1, t0);
      drive_bit(1'b1);
      check_shifts("a5", t0);
      chk("a5 n_load", ld_cyc.size(), 1);
      if (ld_cyc.size() > 0) begin
         chk("a5 load_cyc", ld_cyc[0] - t0, 96);
         chk("a5 data", int'(ld_dat[0]), 'hA5);
      end
      chk("a5 busy_rise", busy_rise - t0, 1);
      chk("a5 busy_fall", busy_fall - t0, 97);
      chk("a5 fe", int'(bus.framing_error), 0);

      clear_log();
      send_frame(8'h3C, 1'b0, t0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      check_shifts("3c", t0);
      chk("3c n_load", ld_cyc.size(), 0);
      chk("3c fe", int'(bus.framing_error), 1);
      chk("3c fe_rise", fe_rise - t0, 96);

      clear_log();
      t0 = cyc + 2;
      bus.serial_in = 1'b0;
      repeat (3) @(negedge clk);
      bus.serial_in = 1'b1;
      repeat (20) @(negedge clk);
      chk("fs busy_rise", busy_rise - t0, 1);
      chk("fs busy_fall", busy_fall - t0, 6);
      chk("fs n_shift", sh_cyc.size(), 0);
      chk("fs fe", int'(bus.framing_error), 1);

      clear_log();
      send_frame(8'h01, 1'b1, t0);
      drive_bit(1'b1);
      check_shifts("01", t0);
      chk("01 fe_fall", fe_fall - t0, 6);
      chk("01 n_load", ld_cyc.size(), 1);
      if (ld_cyc.size() > 0)
         chk("01 data", int'(ld_dat[0]), 'h01);
      chk("01 fe", int'(bus.framing_error), 0);

      clear_log();
      send_frame(8'hFF, 1'b1, t0);
      send_frame(8'h00, 1'b1, t1);
      drive_bit(1'b1);
      chk("b2b n_shift", sh_cyc.size(), 16);
      chk("b2b n_load", ld_cyc.size(), 2);
      if (ld_cyc.size() > 1) begin
         chk("b2b load0", ld_cyc[0] - t0, 96);
         chk("b2b gap", ld_cyc[1] - ld_cyc[0], 100);
         chk("b2b data0", int'(ld_dat[0]), 'hFF);
         chk("b2b data1", int'(ld_dat[1]), 'h00);
      end
      if (sh_cyc.size() > 8)
         chk("b2b shift8", sh_cyc[8] - t1, 15);
      chk("b2b fe", int'(bus.framing_error), 0);

      clear_log();
      t0 = cyc + 2;
      bus.serial_in = 1'b0;
      repeat (300) @(negedge clk);
      check_shifts("stuck", t0);
      chk("stuck n_load", ld_cyc.size(), 0);
      chk("stuck fe", int'(bus.framing_error), 1);
      chk("stuck fe_rise", fe_rise - t0, 96);
      chk("stuck busy_fall", busy_fall - t0, 96);
      chk("stuck n_rise", n_rise, 1);
      chk("stuck busy", int'(bus.busy), 0);

      drive_bit(1'b1);
      drive_bit(1'b1);
      clear_log();
      t0 = cyc + 2;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      chk("mid busy", int'(bus.busy), 1);
      #2;
      rst = 1'b1;
      bus.serial_in = 1'b1;
      #1;
      chk("mid rst shift", int'(bus.shift_enable), 0);
      chk("mid rst load", int'(bus.load_buffer), 0);
      chk("mid rst fe", int'(bus.framing_error), 0);
      chk("mid rst busy", int'(bus.busy), 0);
      chk("mid rst sync", int'(bus.serial_sync), 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      clear_log();
      repeat (120) @(negedge clk);
      chk("post rst sync", int'(bus.serial_sync), 1);
      chk("post rst n_shift", sh_cyc.size(), 0);
      chk("post rst n_load", ld_cyc.size(), 0);
      chk("post rst busy", n_rise, 0);
      chk("never both", both_hi, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
